dsp48a1_mac_sequencer: RTL

//  Sequences one Spartan6_DSP48A1 instance as a streaming multiply-accumulate engine: P = sum(A[i]*B[i]), i=0..len-1.

---
 rtl/dsp48a1_pkg.sv | 42 ++++
 rtl/dsp48a1_opmode_delay.sv | 55 +++++
 rtl/dsp48a1_mac_sequencer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/dsp48a1_pkg.sv
// ----------------------------------------------------------------------------
// dsp48a1_pkg
// Shared definitions for the DSP48A1 MAC sequencer:
//   - OPMODE field encodings for the X and Z post-adder multiplexers
//   - the two OPMODE words the sequencer issues (multiply-clear, multiply-acc)
//   - the sequencer FSM state type
//   - datapath widths of the DSP48A1 ports
// ----------------------------------------------------------------------------
package dsp48a1_pkg;

    // DSP48A1 port widths
    localparam int A_W   = 18;
    localparam int B_W   = 18;
    localparam int P_W   = 48;
    localparam int OPM_W = 8;

    // OPMODE[1:0]: X multiplexer select
    localparam logic [1:0] X_ZERO = 2'b00;
    localparam logic [1:0] X_M    = 2'b01;
    localparam logic [1:0] X_P    = 2'b10;
    localparam logic [1:0] X_DAB  = 2'b11;

    // OPMODE[3:2]: Z multiplexer select
    localparam logic [1:0] Z_ZERO = 2'b00;
    localparam logic [1:0] Z_PCIN = 2'b01;
    localparam logic [1:0] Z_P    = 2'b10;
    localparam logic [1:0] Z_C    = 2'b11;

    // Upper OPMODE bits stay zero: add, no pre-adder, CIN=0.
    // P = M (starts a new sum, discarding whatever P held)
    localparam logic [7:0] OP_MUL_CLR = {4'b0000, Z_ZERO, X_M};
    // P = P + M
    localparam logic [7:0] OP_MAC     = {4'b0000, Z_P, X_M};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/dsp48a1_opmode_delay.sv
// ----------------------------------------------------------------------------
// dsp48a1_opmode_delay
// OPM_SKEW-deep shift register that delays the OPMODE tag so that it reaches
// the DSP OPMODE pin the right number of cycles after its operands reach the
// A/B pins (the DSP registers OPMODE later in its pipeline than A/B).
// Ports:
//   CLK      in   clock, posedge
//   RST      in   synchronous active-high reset, clears the line to 8'h00
//   opm_in   in   tag aligned with the operands on dsp_a/dsp_b
//   opm_out  out  tag delayed by OPM_SKEW cycles
// ----------------------------------------------------------------------------
module dsp48a1_opmode_delay
    import dsp48a1_pkg::*;
#(
    parameter int OPM_SKEW = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [OPM_W-1:0] opm_in,
    output logic [OPM_W-1:0] opm_out
);

    generate
        if (OPM_SKEW == 0) begin : g_bypass
            assign opm_out = opm_in;
        end else begin : g_shift
            logic [OPM_W-1:0] sr_q [OPM_SKEW];
            logic [OPM_W-1:0] sr_d [OPM_SKEW];

            // next value of each stage: shift one position toward the output
            always_comb begin
                sr_d[0] = opm_in;
                for (int i = 1; i < OPM_SKEW; i++) begin
                    sr_d[i] = sr_q[i-1];
                end
            end

            // stage registers
            always_ff @(posedge CLK) begin
                if (RST) begin
                    for (int i = 0; i < OPM_SKEW; i++) begin
                        sr_q[i] <= {OPM_W{1'b0}};
                    end
                end else begin
                    for (int i = 0; i < OPM_SKEW; i++) begin
                        sr_q[i] <= sr_d[i];
                    end
                end
            end

            assign opm_out = sr_q[OPM_SKEW-1];
        end
    endgenerate

endmodule

// File: rtl/dsp48a1_mac_sequencer.sv
// ----------------------------------------------------------------------------
// dsp48a1_mac_sequencer
// Drives an external Spartan-6 DSP48A1 as a streaming multiply-accumulate
// engine computing P = sum(A[i]*B[i]) over a job of len operand pairs.
// Ports:
//   CLK, RST          clock / synchronous active-high reset
//   start, len        job request (sampled in IDLE only) and product count
//   busy              high whenever the FSM is not in IDLE
//   s_valid/s_ready   operand stream handshake, s_a/s_b 18-bit signed
//   r_valid/r_ready   result handshake, r_data 48-bit signed (wraps)
//   dsp_a, dsp_b      operands to the DSP A/B pins
//   dsp_opmode        OPMODE word, skewed to match the DSP OPMODE register
//   dsp_ce, dsp_rst   common clock-enable / reset for every DSP register
//   dsp_p             DSP P output
// ----------------------------------------------------------------------------
module dsp48a1_mac_sequencer
    import dsp48a1_pkg::*;
#(
    parameter int LEN_W    = 8,
    parameter int DATA_LAT = 3,
    parameter int OPM_SKEW = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [A_W-1:0]   s_a,
    input  logic [B_W-1:0]   s_b,
    output logic             r_valid,
    input  logic             r_ready,
    output logic [P_W-1:0]   r_data,
    output logic [A_W-1:0]   dsp_a,
    output logic [B_W-1:0]   dsp_b,
    output logic [OPM_W-1:0] dsp_opmode,
    output logic             dsp_ce,
    output logic             dsp_rst,
    input  logic [P_W-1:0]   dsp_p
);

    localparam int DRN_W = (DATA_LAT < 1) ? 1 : $clog2(DATA_LAT + 1);

    state_t             state_q,   state_d;
    logic [LEN_W-1:0]   cnt_q,     cnt_d;
    logic               first_q,   first_d;
    logic [DRN_W-1:0]   drain_q,   drain_d;
    logic               busy_q,    busy_d;
    logic               s_ready_q, s_ready_d;
    logic               r_valid_q, r_valid_d;
    logic [P_W-1:0]     r_data_q,  r_data_d;
    logic [A_W-1:0]     dsp_a_q,   dsp_a_d;
    logic [B_W-1:0]     dsp_b_q,   dsp_b_d;
    logic [OPM_W-1:0]   tag_q,     tag_d;
    logic               dsp_ce_q,  dsp_ce_d;
    logic               dsp_rst_q, dsp_rst_d;

    // next-state and next-output logic of the sequencer FSM
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        first_d   = first_q;
        drain_d   = drain_q;
        s_ready_d = s_ready_q;
        r_valid_d = r_valid_q;
        r_data_d  = r_data_q;
        // default is a bubble: zero operands give M=0
        dsp_a_d   = {A_W{1'b0}};
        dsp_b_d   = {B_W{1'b0}};
        tag_d     = OP_MAC;
        dsp_ce_d  = dsp_ce_q;
        dsp_rst_d = 1'b0;

        case (state_q)
            IDLE: begin
                s_ready_d = 1'b0;
                r_valid_d = 1'b0;
                dsp_ce_d  = 1'b0;
                tag_d     = OP_MUL_CLR;
                if (start) begin
                    if (len == {LEN_W{1'b0}}) begin
                        // empty job: answer immediately, DSP stays frozen
                        state_d   = DONE;
                        r_data_d  = {P_W{1'b0}};
                        r_valid_d = 1'b1;
                    end else begin
                        state_d   = RUN;
                        cnt_d     = len;
                        first_d   = 1'b1;
                        s_ready_d = 1'b1;
                        dsp_ce_d  = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end

            RUN: begin
                // bubbles before the first pair may clear P; the first real
                // product clears it again, so this is harmless
                tag_d = first_q ? OP_MUL_CLR : OP_MAC;
                if (s_valid && s_ready_q) begin
                    dsp_a_d = s_a;
                    dsp_b_d = s_b;
                    first_d = 1'b0;
                    cnt_d   = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        s_ready_d = 1'b0;
                        drain_d   = {DRN_W{1'b0}};
                        state_d   = DRAIN;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    state_d = RUN;
                end
            end

            DRAIN: begin
                // drain_q counts cycles since the last pair sat on dsp_a/dsp_b;
                // once it reaches DATA_LAT the final sum is on dsp_p
                if (drain_q == DRN_W'(DATA_LAT)) begin
                    r_data_d  = dsp_p;
                    r_valid_d = 1'b1;
                    dsp_ce_d  = 1'b0;
                    state_d   = DONE;
                end else begin
                    drain_d = drain_q + DRN_W'(1);
                    state_d = DRAIN;
                end
            end

            DONE: begin
                dsp_ce_d = 1'b0;
                if (r_valid_q && r_ready) begin
                    r_valid_d = 1'b0;
                    state_d   = IDLE;
                end else begin
                    state_d = DONE;
                end
            end

            default: begin
                state_d   = IDLE;
                s_ready_d = 1'b0;
                r_valid_d = 1'b0;
                dsp_ce_d  = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // state and registered outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            cnt_q     <= {LEN_W{1'b0}};
            first_q   <= 1'b0;
            drain_q   <= {DRN_W{1'b0}};
            busy_q    <= 1'b0;
            s_ready_q <= 1'b0;
            r_valid_q <= 1'b0;
            r_data_q  <= {P_W{1'b0}};
            dsp_a_q   <= {A_W{1'b0}};
            dsp_b_q   <= {B_W{1'b0}};
            tag_q     <= {OPM_W{1'b0}};
            dsp_ce_q  <= 1'b0;
            dsp_rst_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            first_q   <= first_d;
            drain_q   <= drain_d;
            busy_q    <= busy_d;
            s_ready_q <= s_ready_d;
            r_valid_q <= r_valid_d;
            r_data_q  <= r_data_d;
            dsp_a_q   <= dsp_a_d;
            dsp_b_q   <= dsp_b_d;
            tag_q     <= tag_d;
            dsp_ce_q  <= dsp_ce_d;
            dsp_rst_q <= dsp_rst_d;
        end
    end

    // tag_q is aligned with dsp_a/dsp_b; delay it onto the OPMODE pin
    dsp48a1_opmode_delay #(
        .OPM_SKEW (OPM_SKEW)
    ) u_opm_delay (
        .CLK     (CLK),
        .RST     (RST),
        .opm_in  (tag_q),
        .opm_out (dsp_opmode)
    );

    assign busy    = busy_q;
    assign s_ready = s_ready_q;
    assign r_valid = r_valid_q;
    assign r_data  = r_data_q;
    assign dsp_a   = dsp_a_q;
    assign dsp_b   = dsp_b_q;
    assign dsp_ce  = dsp_ce_q;
    assign dsp_rst = dsp_rst_q;

endmodule
